// File: rtl/bullet_launcher_pkg.sv
// Shared definitions for the bullet launcher and the bullet instances it drives:
// launch FSM encoding, playfield geometry and direction encoding.
package bullet_launcher_pkg;

    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } launch_state_t;

endpackage

// File: rtl/fire_edge_sync.sv
// Two-flop synchronizer for a raw button level followed by a rising-edge
// detector; produces a single-cycle pulse per press however long it is held.
module fire_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/bullet_launcher.sv
// Fire-button to bullet-slot launcher: picks the lowest free slot, holds a
// start request until the slot reports in-use, then enforces a refire cooldown.
import bullet_launcher_pkg::*;

module bullet_launcher #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 3
) (
    input  logic                 clk_60hz,
    input  logic                 reset,
    input  logic                 fire_btn,
    input  logic                 fire_dir,
    input  logic [COORD_W-1:0]   shipX,
    input  logic [NUM_SLOTS-1:0] slot_in_use,
    output logic [NUM_SLOTS-1:0] start_bullet,
    output logic                 direction,
    output logic [COORD_W-1:0]   bulletX,
    output logic                 cooldown_active,
    output logic [7:0]           shots_fired,
    output logic [7:0]           shots_dropped
);

    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    launch_state_t    state;
    launch_state_t    state_next;
    logic             fire_req;
    logic             any_free;
    logic [SEL_W-1:0] free_idx;
    logic [SEL_W-1:0] sel;
    logic             ack;
    logic             timed_out;
    logic [7:0]       cooldown_cnt;
    logic [3:0]       timeout_cnt;

    fire_edge_sync u_fire_sync (
        .clk   (clk_60hz),
        .reset (reset),
        .btn   (fire_btn),
        .rise  (fire_req)
    );

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_in_use[i]) begin
                any_free = 1'b1;
                free_idx = SEL_W'(i);
            end
        end
    end

    assign ack       = slot_in_use[sel];
    assign timed_out = (timeout_cnt == 4'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_60hz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fire_req && any_free) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (ack) begin
                    state_next = COOLDOWN;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            COOLDOWN: begin
                if (cooldown_cnt <= 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shot parameters are captured only on acceptance so they stay frozen through ISSUE.
    always_ff @(posedge clk_60hz) begin
        if (reset) begin
            sel           <= '0;
            bulletX       <= '0;
            direction     <= DIR_DOWN;
            cooldown_cnt  <= '0;
            timeout_cnt   <= '0;
            shots_fired   <= '0;
            shots_dropped <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_cnt <= '0;
                    if (fire_req) begin
                        if (any_free) begin
                            sel       <= free_idx;
                            bulletX   <= shipX;
                            direction <= fire_dir;
                        end else begin
                            shots_dropped <= shots_dropped + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (ack) begin
                        shots_fired  <= shots_fired + 8'd1;
                        cooldown_cnt <= 8'(COOLDOWN_FRAMES);
                    end else if (timed_out) begin
                        shots_dropped <= shots_dropped + 8'd1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 4'd1;
                    end
                end
                COOLDOWN: begin
                    cooldown_cnt <= cooldown_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        start_bullet = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            start_bullet[i] = (state == ISSUE) && (sel == SEL_W'(i));
        end
        cooldown_active = (state == COOLDOWN);
    end

endmodule
